// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (I-cache / D-cache) block memory arbiter.
// Round-robin on contention, one registered memory transaction per grant.
//
// Ports:
//   clk, rst_n              clock (rising edge), synchronous active-low reset
//   i_read/i_write/i_addr   I-cache block request, i_wdata write block
//   i_rdata/i_ready         I-cache read block and completion strobe
//   d_read/d_write/d_addr   D-cache block request, d_wdata write block
//   d_rdata/d_ready         D-cache read block and completion strobe
//   mem_read/mem_write      memory strobes (registered, never both high)
//   mem_addr/mem_wdata      memory block address / write block (registered)
//   mem_rdata/mem_ready     memory read block and completion
module mem_arbiter #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_read,
   input  logic              i_write,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ready,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GNT_I   = 2'd1,
      GNT_D   = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t            r_state;
   logic              r_last_gnt;
   logic              r_mem_read;
   logic              r_mem_write;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [DATA_W-1:0] r_i_rdata;
   logic [DATA_W-1:0] r_d_rdata;

   logic w_i_req;
   logic w_d_req;
   logic w_pick_d;
   logic w_i_done;
   logic w_d_done;

   assign w_i_req = i_read | i_write;
   assign w_d_req = d_read | d_write;

   // D wins unless I is also asking and D held the previous grant.
   assign w_pick_d = w_d_req & ~(w_i_req & r_last_gnt);

   // Completion is suppressed while reset is asserted so an
   // aborted transfer never produces a ready pulse.
   assign w_i_done = rst_n & (r_state == GNT_I) & mem_ready;
   assign w_d_done = rst_n & (r_state == GNT_D) & mem_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_last_gnt  <= 1'b0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_i_rdata   <= '0;
         r_d_rdata   <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_pick_d) begin
                  r_state     <= GNT_D;
                  r_last_gnt  <= 1'b1;
                  r_mem_write <= d_write;
                  r_mem_read  <= d_read & ~d_write;
                  r_mem_addr  <= d_addr;
                  r_mem_wdata <= d_wdata;
               end else if (w_i_req) begin
                  r_state     <= GNT_I;
                  r_last_gnt  <= 1'b0;
                  r_mem_write <= i_write;
                  r_mem_read  <= i_read & ~i_write;
                  r_mem_addr  <= i_addr;
                  r_mem_wdata <= i_wdata;
               end
            end
            GNT_I: begin
               if (mem_ready) begin
                  r_state     <= RELEASE;
                  r_mem_read  <= 1'b0;
                  r_mem_write <= 1'b0;
                  r_i_rdata   <= mem_rdata;
               end
            end
            GNT_D: begin
               if (mem_ready) begin
                  r_state     <= RELEASE;
                  r_mem_read  <= 1'b0;
                  r_mem_write <= 1'b0;
                  r_d_rdata   <= mem_rdata;
               end
            end
            // One dead cycle lets the caches drop their
            // registered requests before we arbitrate again.
            RELEASE: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign mem_read  = r_mem_read;
   assign mem_write = r_mem_write;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

   assign i_ready = w_i_done;
   assign d_ready = w_d_done;
   assign i_rdata = w_i_done ? mem_rdata : r_i_rdata;
   assign d_rdata = w_d_done ? mem_rdata : r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter
// against a transaction-level reference model.
module tb_mem_arbiter;

   logic         clk;
   logic         rst_n;
   logic         i_read, i_write;
   logic [27:0]  i_addr;
   logic [127:0] i_wdata, i_rdata;
   logic         i_ready;
   logic         d_read, d_write;
   logic [27:0]  d_addr;
   logic [127:0] d_wdata, d_rdata;
   logic         d_ready;
   logic         mem_read, mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata, mem_rdata;
   logic         mem_ready;

   mem_arbiter #(.ADDR_W(28), .DATA_W(128)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_read(i_read), .i_write(i_write), .i_addr(i_addr),
      .i_wdata(i_wdata), .i_rdata(i_rdata), .i_ready(i_ready),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Reference model: who owns memory, the pending transaction,
   // whether we are in the post-transfer dead cycle, and who was served last.
   int           m_side;
   bit           m_cool;
   bit           m_last;
   logic         m_rd, m_wr;
   logic [27:0]  m_addr;
   logic [127:0] m_wdata, m_irdata, m_drdata;

   // Snapshots of DUT outputs at the last sample point
   logic         o_mem_read, o_mem_write, o_i_ready, o_d_ready;
   logic [27:0]  o_mem_addr;
   logic [127:0] o_mem_wdata, o_i_rdata, o_d_rdata;

   localparam logic [127:0] PAT_A5 = {16{8'hA5}};
   localparam logic [127:0] R1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
   localparam logic [127:0] R2 = 128'hDEAD_BEEF_0000_1234_CAFE_F00D_9876_5432;
   localparam logic [127:0] W1 = 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10;
   localparam logic [127:0] W2 = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;

   task automatic check(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: sample outputs, compare with model, advance model.
   task automatic step();
      bit           done, ei, ed, ri, rq;
      int           pick;
      logic [127:0] eir, edr;
      #1;
      o_mem_read  = mem_read;
      o_mem_write = mem_write;
      o_mem_addr  = mem_addr;
      o_mem_wdata = mem_wdata;
      o_i_ready   = i_ready;
      o_d_ready   = d_ready;
      o_i_rdata   = i_rdata;
      o_d_rdata   = d_rdata;
      done = rst_n && (m_side >= 0) && mem_ready;
      ei  = done && (m_side == 0);
      ed  = done && (m_side == 1);
      eir = ei ? mem_rdata : m_irdata;
      edr = ed ? mem_rdata : m_drdata;
      if (chk_en) begin
         check("m_mem_read", 128'(mem_read), 128'(m_rd));
         check("m_mem_write", 128'(mem_write), 128'(m_wr));
         check("m_mem_addr", 128'(mem_addr), 128'(m_addr));
         check("m_mem_wdata", mem_wdata, m_wdata);
         check("m_i_ready", 128'(i_ready), 128'(ei));
         check("m_d_ready", 128'(d_ready), 128'(ed));
         check("m_i_rdata", i_rdata, eir);
         check("m_d_rdata", d_rdata, edr);
         check("m_rw_excl", 128'(mem_read & mem_write), 128'(0));
      end
      if (!rst_n) begin
         m_side = -1; m_cool = 0; m_last = 0;
         m_rd = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
         m_irdata = '0; m_drdata = '0;
      end else if (m_side >= 0) begin
         if (mem_ready) begin
            if (m_side == 0) m_irdata = mem_rdata;
            else m_drdata = mem_rdata;
            m_side = -1; m_cool = 1; m_rd = 0; m_wr = 0;
         end
      end else if (m_cool) begin
         m_cool = 0;
      end else begin
         ri = i_read | i_write;
         rq = d_read | d_write;
         pick = -1;
         if (ri && rq) pick = m_last ? 0 : 1;
         else if (rq) pick = 1;
         else if (ri) pick = 0;
         if (pick == 0) begin
            m_side = 0; m_last = 0;
            m_wr = i_write; m_rd = i_read & ~i_write;
            m_addr = i_addr; m_wdata = i_wdata;
         end else if (pick == 1) begin
            m_side = 1; m_last = 1;
            m_wr = d_write; m_rd = d_read & ~d_write;
            m_addr = d_addr; m_wdata = d_wdata;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic quiet();
      i_read = 0; i_write = 0; d_read = 0; d_write = 0;
      mem_ready = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      m_side = -1; m_cool = 0; m_last = 0;
      m_rd = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
      m_irdata = '0; m_drdata = '0;
      rst_n = 0;
      quiet();
      i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0;
      mem_rdata = '0;

      // Reset
      step();
      chk_en = 1;
      step();
      rst_n = 1;
      step();
      check("rst_mem_read", 128'(o_mem_read), 128'(0));
      check("rst_mem_addr", 128'(o_mem_addr), 128'(0));
      check("rst_d_rdata", o_d_rdata, 128'(0));
      check("rst_i_ready", 128'(o_i_ready), 128'(0));

      // D-only read, memory ready on third grant cycle
      d_read = 1; d_addr = 28'h0000010; mem_rdata = PAT_A5;
      step();
      check("donly_latency", 128'(o_mem_read), 128'(0));
      for (int k = 0; k < 3; k++) begin
         mem_ready = (k == 2);
         step();
         check("donly_mem_read", 128'(o_mem_read), 128'(1));
         check("donly_mem_addr", 128'(o_mem_addr), 128'(28'h0000010));
         check("donly_i_ready", 128'(o_i_ready), 128'(0));
         check("donly_d_ready", 128'(o_d_ready), 128'(k == 2));
      end
      check("donly_d_rdata", o_d_rdata, PAT_A5);
      mem_ready = 0;
      step();
      check("stale_release", 128'(o_mem_read), 128'(0));
      check("stale_d_rdata", o_d_rdata, PAT_A5);
      d_read = 0;
      step();
      check("stale_idle", 128'(o_mem_read), 128'(0));
      step();
      check("stale_after", 128'(o_mem_read), 128'(0));

      // Simultaneous request right after reset: D first, then I
      rst_n = 0;
      step();
      rst_n = 1;
      i_read = 1; i_addr = 28'h1;
      d_write = 1; d_addr = 28'h2; d_wdata = W1;
      step();
      step();
      check("sim_d_write", 128'(o_mem_write), 128'(1));
      check("sim_d_read", 128'(o_mem_read), 128'(0));
      check("sim_d_addr", 128'(o_mem_addr), 128'(28'h2));
      check("sim_d_wdata", o_mem_wdata, W1);
      mem_ready = 1;
      step();
      check("sim_d_ready", 128'(o_d_ready), 128'(1));
      check("sim_i_ready0", 128'(o_i_ready), 128'(0));
      mem_ready = 0;
      step();
      check("sim_rel_wr", 128'(o_mem_write), 128'(0));
      d_write = 0;
      step();
      check("sim_idle_rd", 128'(o_mem_read), 128'(0));
      step();
      check("sim_i_read", 128'(o_mem_read), 128'(1));
      check("sim_i_addr", 128'(o_mem_addr), 128'(28'h1));
      mem_ready = 1; mem_rdata = R1;
      step();
      check("sim_i_ready", 128'(o_i_ready), 128'(1));
      check("sim_i_rdata", o_i_rdata, R1);
      check("sim_d_ready0", 128'(o_d_ready), 128'(0));
      mem_ready = 0;
      step();
      i_read = 0;
      step();

      // Round-robin: one D grant, then 4 contended transfers
      d_read = 1; d_addr = 28'h200;
      step();
      mem_ready = 1;
      step();
      mem_ready = 0;
      i_read = 1; i_addr = 28'h100;
      step();
      for (int t = 0; t < 4; t++) begin
         step();
         mem_ready = 1; mem_rdata = {4{$urandom}};
         step();
         check("rr_addr", 128'(o_mem_addr),
               (t % 2 == 0) ? 128'(28'h100) : 128'(28'h200));
         check("rr_i_ready", 128'(o_i_ready), 128'(t % 2 == 0));
         check("rr_d_ready", 128'(o_d_ready), 128'(t % 2 == 1));
         mem_ready = 0;
         step();
      end
      quiet();
      step();
      step();

      // Reset during GNT_I before mem_ready
      i_read = 1; i_addr = 28'h33;
      step();
      step();
      check("rst_mid_rd", 128'(o_mem_read), 128'(1));
      check("rst_mid_addr", 128'(o_mem_addr), 128'(28'h33));
      rst_n = 0;
      step();
      check("rst_mid_i_ready", 128'(o_i_ready), 128'(0));
      rst_n = 1; i_read = 0;
      d_read = 1; d_addr = 28'h44;
      step();
      check("rst_post_rd", 128'(o_mem_read), 128'(0));
      check("rst_post_i_ready", 128'(o_i_ready), 128'(0));
      step();
      check("rst_post_d_rd", 128'(o_mem_read), 128'(1));
      check("rst_post_d_addr", 128'(o_mem_addr), 128'(28'h44));
      mem_ready = 1; mem_rdata = R2;
      step();
      check("rst_post_d_ready", 128'(o_d_ready), 128'(1));
      check("rst_post_d_rdata", o_d_rdata, R2);
      quiet();
      step();
      step();

      // Spurious mem_ready in IDLE, then read+write from I counts as write
      mem_ready = 1; mem_rdata = R1;
      step();
      check("spur_i_ready", 128'(o_i_ready), 128'(0));
      check("spur_d_ready", 128'(o_d_ready), 128'(0));
      check("spur_d_rdata", o_d_rdata, R2);
      check("spur_i_rdata", o_i_rdata, 128'(0));
      mem_ready = 0;
      i_read = 1; i_write = 1; i_addr = 28'h55; i_wdata = W2;
      step();
      check("spur_idle_wr", 128'(o_mem_write), 128'(0));
      step();
      check("rw_i_write", 128'(o_mem_write), 128'(1));
      check("rw_i_read", 128'(o_mem_read), 128'(0));
      check("rw_i_wdata", o_mem_wdata, W2);
      mem_ready = 1;
      step();
      check("rw_i_ready", 128'(o_i_ready), 128'(1));
      quiet();
      step();
      step();

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         rst_n     = ($urandom_range(99) != 0);
         i_read    = ($urandom_range(2) == 0);
         i_write   = ($urandom_range(3) == 0);
         d_read    = ($urandom_range(2) == 0);
         d_write   = ($urandom_range(3) == 0);
         i_addr    = 28'($urandom);
         d_addr    = 28'($urandom);
         i_wdata   = {$urandom, $urandom, $urandom, $urandom};
         d_wdata   = {$urandom, $urandom, $urandom, $urandom};
         mem_ready = ($urandom_range(2) == 0);
         mem_rdata = {$urandom, $urandom, $urandom, $urandom};
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
